// File: rtl/mmc_sdp_resp_cntl.sv
// mmc_sdp_resp_cntl: main-memory responder for the storage-descriptor
// request/stream protocol. Forwards line read requests to DRAM, keeps the
// request address of every outstanding read in a per-channel FIFO, buffers the
// returned lines per channel and hands them out in request order.
// Optional feature macro: MMC_RESP_PROTOCOL_CHECK_EN (sticky protocol error
// flag and dropping of unexpected DRAM returns).
module mmc_sdp_resp_cntl #(
  parameter int NUM_CHANNELS = 2,
  parameter int CHAN_W       = 1,
  parameter int BANK_W       = 3,
  parameter int PAGE_W       = 15,
  parameter int WORD_W       = 7,
  parameter int DATA_W       = 256,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                                 clk,
  input  logic                                 reset_poweron,
  input  logic                                 xxx__mmc__req_valid,
  input  logic [1:0]                           xxx__mmc__req_cntl,
  output logic                                 mmc__xxx__req_ready,
  input  logic [CHAN_W-1:0]                    xxx__mmc__req_channel,
  input  logic [BANK_W-1:0]                    xxx__mmc__req_bank,
  input  logic [PAGE_W-1:0]                    xxx__mmc__req_page,
  input  logic [WORD_W-1:0]                    xxx__mmc__req_word,
  output logic                                 mmc__dram__cmd_valid,
  output logic [CHAN_W-1:0]                    mmc__dram__cmd_channel,
  output logic [BANK_W-1:0]                    mmc__dram__cmd_bank,
  output logic [PAGE_W-1:0]                    mmc__dram__cmd_page,
  output logic [WORD_W-1:0]                    mmc__dram__cmd_word,
  input  logic                                 dram__mmc__cmd_ready,
  input  logic                                 dram__mmc__rd_valid,
  input  logic [CHAN_W-1:0]                    dram__mmc__rd_channel,
  input  logic [DATA_W-1:0]                    dram__mmc__rd_data,
  output logic [NUM_CHANNELS-1:0]              mmc__xxx__mem_request_valid,
  output logic [NUM_CHANNELS-1:0][1:0]         mmc__xxx__mem_request_cntl,
  output logic [NUM_CHANNELS-1:0][CHAN_W-1:0]  mmc__xxx__mem_request_channel,
  output logic [NUM_CHANNELS-1:0][BANK_W-1:0]  mmc__xxx__mem_request_bank,
  output logic [NUM_CHANNELS-1:0][PAGE_W-1:0]  mmc__xxx__mem_request_page,
  output logic [NUM_CHANNELS-1:0][WORD_W-1:0]  mmc__xxx__mem_request_word,
  output logic [NUM_CHANNELS-1:0]              mmc__xxx__channel_data_valid,
  output logic [NUM_CHANNELS-1:0][DATA_W-1:0]  mmc__xxx__line_data,
  input  logic [NUM_CHANNELS-1:0]              xxx__mmc__get_next_line,
  output logic                                 mmc__xxx__error
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int RQ_W = 2 + CHAN_W + BANK_W + PAGE_W + WORD_W;
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  typedef logic [AW:0] ptr_t;

  logic [RQ_W-1:0]   rq_mem [NUM_CHANNELS][FIFO_DEPTH];
  logic [DATA_W-1:0] ln_mem [NUM_CHANNELS][FIFO_DEPTH];

  ptr_t rq_wptr  [NUM_CHANNELS];
  ptr_t rq_rptr  [NUM_CHANNELS];
  ptr_t ln_wptr  [NUM_CHANNELS];
  ptr_t ln_rptr  [NUM_CHANNELS];
  ptr_t out_cnt  [NUM_CHANNELS];
  ptr_t ln_count [NUM_CHANNELS];

  logic [NUM_CHANNELS-1:0] rq_empty;
  logic [NUM_CHANNELS-1:0] rq_full;
  logic [NUM_CHANNELS-1:0] ln_empty;
  logic [NUM_CHANNELS-1:0] rq_push;
  logic [NUM_CHANNELS-1:0] ln_push;
  logic [NUM_CHANNELS-1:0] rd_hit;
  logic [NUM_CHANNELS-1:0] pop;
  logic                    accept;

`ifdef MMC_RESP_PROTOCOL_CHECK_EN
  logic [NUM_CHANNELS-1:0] ln_full;
  logic [NUM_CHANNELS-1:0] rd_bad;
  logic                    err_set;
`endif

  // FIFO occupancy: the extra pointer MSB separates full from empty
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      rq_empty[c] = (rq_wptr[c] == rq_rptr[c]);
      rq_full[c]  = ((rq_wptr[c] - rq_rptr[c]) == DEPTH);
      ln_count[c] = ln_wptr[c] - ln_rptr[c];
      ln_empty[c] = (ln_count[c] == '0);
`ifdef MMC_RESP_PROTOCOL_CHECK_EN
      ln_full[c]  = (ln_count[c] == DEPTH);
`endif
    end
  end

  // Request acceptance; cmd_valid never looks at cmd_ready, ready is pre-pop
  always_comb begin
    mmc__dram__cmd_valid   = !reset_poweron && xxx__mmc__req_valid &&
                             !rq_full[xxx__mmc__req_channel] &&
                             (out_cnt[xxx__mmc__req_channel] < DEPTH);
    accept                 = mmc__dram__cmd_valid && dram__mmc__cmd_ready;
    mmc__xxx__req_ready    = accept;
    mmc__dram__cmd_channel = xxx__mmc__req_channel;
    mmc__dram__cmd_bank    = xxx__mmc__req_bank;
    mmc__dram__cmd_page    = xxx__mmc__req_page;
    mmc__dram__cmd_word    = xxx__mmc__req_word;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      rq_push[c] = accept && (xxx__mmc__req_channel == CHAN_W'(c));
    end
  end

  // Line presentation, pops, DRAM return steering and optional error checks
  always_comb begin
`ifdef MMC_RESP_PROTOCOL_CHECK_EN
    err_set = 1'b0;
`endif
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      mmc__xxx__channel_data_valid[c] = !ln_empty[c] && !rq_empty[c];
      pop[c]    = xxx__mmc__get_next_line[c] && mmc__xxx__channel_data_valid[c];
      rd_hit[c] = dram__mmc__rd_valid && (dram__mmc__rd_channel == CHAN_W'(c));
`ifdef MMC_RESP_PROTOCOL_CHECK_EN
      rd_bad[c]  = rd_hit[c] && ((out_cnt[c] == '0) ||
                                 (ln_count[c] == out_cnt[c]) || ln_full[c]);
      ln_push[c] = rd_hit[c] && !rd_bad[c];
      if (rd_bad[c] || (xxx__mmc__get_next_line[c] && !mmc__xxx__channel_data_valid[c]))
        err_set = 1'b1;
`else
      ln_push[c] = rd_hit[c];
`endif
    end
  end

  // Head fields of each channel, forced to zero while nothing is queued
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      mmc__xxx__mem_request_valid[c] = !rq_empty[c];
      {mmc__xxx__mem_request_cntl[c], mmc__xxx__mem_request_channel[c],
       mmc__xxx__mem_request_bank[c], mmc__xxx__mem_request_page[c],
       mmc__xxx__mem_request_word[c]} =
        rq_empty[c] ? '0 : rq_mem[c][rq_rptr[c][AW-1:0]];
      mmc__xxx__line_data[c] = mmc__xxx__channel_data_valid[c] ?
                               ln_mem[c][ln_rptr[c][AW-1:0]] : '0;
    end
  end

  // Pointers and outstanding counters; reset flushes every channel
  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        rq_wptr[c] <= '0;
        rq_rptr[c] <= '0;
        ln_wptr[c] <= '0;
        ln_rptr[c] <= '0;
        out_cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (rq_push[c]) rq_wptr[c] <= rq_wptr[c] + ptr_t'(1);
        if (ln_push[c]) ln_wptr[c] <= ln_wptr[c] + ptr_t'(1);
        if (pop[c]) begin
          rq_rptr[c] <= rq_rptr[c] + ptr_t'(1);
          ln_rptr[c] <= ln_rptr[c] + ptr_t'(1);
        end
        case ({rq_push[c], pop[c]})
          2'b10:   out_cnt[c] <= out_cnt[c] + ptr_t'(1);
          2'b01:   out_cnt[c] <= out_cnt[c] - ptr_t'(1);
          default: out_cnt[c] <= out_cnt[c];
        endcase
      end
    end
  end

  // FIFO storage arrays, written at the current write pointer
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (rq_push[c])
        rq_mem[c][rq_wptr[c][AW-1:0]] <= {xxx__mmc__req_cntl, xxx__mmc__req_channel,
                                          xxx__mmc__req_bank, xxx__mmc__req_page,
                                          xxx__mmc__req_word};
      if (ln_push[c])
        ln_mem[c][ln_wptr[c][AW-1:0]] <= dram__mmc__rd_data;
    end
  end

`ifdef MMC_RESP_PROTOCOL_CHECK_EN
  // Sticky protocol error, cleared only by reset
  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron)
      mmc__xxx__error <= 1'b0;
    else if (err_set)
      mmc__xxx__error <= 1'b1;
  end
`else
  assign mmc__xxx__error = 1'b0;
`endif

endmodule

// File: tb/tb_mmc_sdp_resp_cntl.sv
// tb_mmc_sdp_resp_cntl: directed self-checking bench for mmc_sdp_resp_cntl.
// Honours MMC_RESP_PROTOCOL_CHECK_EN to select the expected error behaviour.
module tb_mmc_sdp_resp_cntl;

  localparam int NC = 2;
  localparam int CW = 1;
  localparam int BW = 3;
  localparam int PW = 15;
  localparam int WW = 7;
  localparam int DW = 256;

`ifdef MMC_RESP_PROTOCOL_CHECK_EN
  localparam logic EXP_ERR    = 1'b1;
  localparam logic EXP_STORED = 1'b0;
`else
  localparam logic EXP_ERR    = 1'b0;
  localparam logic EXP_STORED = 1'b1;
`endif

  logic                   clk = 1'b0;
  logic                   reset_poweron;
  logic                   req_valid;
  logic [1:0]             req_cntl;
  logic                   req_ready;
  logic [CW-1:0]          req_channel;
  logic [BW-1:0]          req_bank;
  logic [PW-1:0]          req_page;
  logic [WW-1:0]          req_word;
  logic                   cmd_valid;
  logic [CW-1:0]          cmd_channel;
  logic [BW-1:0]          cmd_bank;
  logic [PW-1:0]          cmd_page;
  logic [WW-1:0]          cmd_word;
  logic                   cmd_ready;
  logic                   rd_valid;
  logic [CW-1:0]          rd_channel;
  logic [DW-1:0]          rd_data;
  logic [NC-1:0]          mr_valid;
  logic [NC-1:0][1:0]     mr_cntl;
  logic [NC-1:0][CW-1:0]  mr_channel;
  logic [NC-1:0][BW-1:0]  mr_bank;
  logic [NC-1:0][PW-1:0]  mr_page;
  logic [NC-1:0][WW-1:0]  mr_word;
  logic [NC-1:0]          cd_valid;
  logic [NC-1:0][DW-1:0]  line_data;
  logic [NC-1:0]          get_next_line;
  logic                   error;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mmc_sdp_resp_cntl dut (
    .clk                           (clk),
    .reset_poweron                 (reset_poweron),
    .xxx__mmc__req_valid           (req_valid),
    .xxx__mmc__req_cntl            (req_cntl),
    .mmc__xxx__req_ready           (req_ready),
    .xxx__mmc__req_channel         (req_channel),
    .xxx__mmc__req_bank            (req_bank),
    .xxx__mmc__req_page            (req_page),
    .xxx__mmc__req_word            (req_word),
    .mmc__dram__cmd_valid          (cmd_valid),
    .mmc__dram__cmd_channel        (cmd_channel),
    .mmc__dram__cmd_bank           (cmd_bank),
    .mmc__dram__cmd_page           (cmd_page),
    .mmc__dram__cmd_word           (cmd_word),
    .dram__mmc__cmd_ready          (cmd_ready),
    .dram__mmc__rd_valid           (rd_valid),
    .dram__mmc__rd_channel         (rd_channel),
    .dram__mmc__rd_data            (rd_data),
    .mmc__xxx__mem_request_valid   (mr_valid),
    .mmc__xxx__mem_request_cntl    (mr_cntl),
    .mmc__xxx__mem_request_channel (mr_channel),
    .mmc__xxx__mem_request_bank    (mr_bank),
    .mmc__xxx__mem_request_page    (mr_page),
    .mmc__xxx__mem_request_word    (mr_word),
    .mmc__xxx__channel_data_valid  (cd_valid),
    .mmc__xxx__line_data           (line_data),
    .xxx__mmc__get_next_line       (get_next_line),
    .mmc__xxx__error               (error)
  );

  // Count one comparison and report it when the observed value differs
  task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drive the request port
  task automatic applyStimulus(input logic v, input logic [1:0] cntl, input logic [CW-1:0] ch,
                               input logic [BW-1:0] bank, input logic [PW-1:0] page,
                               input logic [WW-1:0] word);
    req_valid   = v;
    req_cntl    = cntl;
    req_channel = ch;
    req_bank    = bank;
    req_page    = page;
    req_word    = word;
  endtask

  // Advance to just after the next rising edge
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Present one DRAM return line
  task automatic returnLine(input logic [CW-1:0] ch, input logic [DW-1:0] data);
    rd_valid   = 1'b1;
    rd_channel = ch;
    rd_data    = data;
  endtask

  initial begin
    reset_poweron = 1'b1;
    cmd_ready     = 1'b1;
    rd_valid      = 1'b0;
    rd_channel    = '0;
    rd_data       = '0;
    get_next_line = '0;
    applyStimulus(1'b1, 2'b11, 1'b0, 3'd1, 15'h1, 7'h1);

    // reset state, request held valid to show gating
    @(negedge clk);
    checkOutput("rst_mr_valid", mr_valid, 2'b00);
    checkOutput("rst_cd_valid", cd_valid, 2'b00);
    checkOutput("rst_req_ready", req_ready, 1'b0);
    checkOutput("rst_cmd_valid", cmd_valid, 1'b0);
    checkOutput("rst_error", error, 1'b0);
    checkOutput("rst_head_page", mr_page[0], 15'h0);
    nextCycle();
    reset_poweron = 1'b0;
    applyStimulus(1'b0, 2'b00, 1'b0, 3'd0, 15'h0, 7'h0);
    nextCycle();

    // single request round trip on channel 0
    applyStimulus(1'b1, 2'b11, 1'b0, 3'd2, 15'h10, 7'h40);
    @(negedge clk);
    checkOutput("t1_cmd_valid", cmd_valid, 1'b1);
    checkOutput("t1_req_ready", req_ready, 1'b1);
    checkOutput("t1_cmd_page", cmd_page, 15'h10);
    checkOutput("t1_mr_before", mr_valid, 2'b00);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 1'b0, 3'd0, 15'h0, 7'h0);
    @(negedge clk);
    checkOutput("t1_mr_valid", mr_valid, 2'b01);
    checkOutput("t1_head_cntl", mr_cntl[0], 2'b11);
    checkOutput("t1_head_bank", mr_bank[0], 3'd2);
    checkOutput("t1_head_page", mr_page[0], 15'h10);
    checkOutput("t1_head_word", mr_word[0], 7'h40);
    checkOutput("t1_cd_before", cd_valid, 2'b00);
    nextCycle();
    returnLine(1'b0, {8{32'hA5A5A5A5}});
    nextCycle();
    rd_valid = 1'b0;
    @(negedge clk);
    checkOutput("t1_cd_valid", cd_valid, 2'b01);
    checkOutput("t1_line", line_data[0], {8{32'hA5A5A5A5}});
    nextCycle();
    get_next_line = 2'b01;
    nextCycle();
    get_next_line = 2'b00;
    @(negedge clk);
    checkOutput("t1_mr_after_pop", mr_valid, 2'b00);
    checkOutput("t1_cd_after_pop", cd_valid, 2'b00);

    // cmd_ready low for 3 cycles on channel 1
    nextCycle();
    cmd_ready = 1'b0;
    applyStimulus(1'b1, 2'b01, 1'b1, 3'd0, 15'd0, 7'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t3_stall_cmd_valid", cmd_valid, 1'b1);
      checkOutput("t3_stall_req_ready", req_ready, 1'b0);
      checkOutput("t3_stall_no_push", mr_valid, 2'b00);
      nextCycle();
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    checkOutput("t3_accept", req_ready, 1'b1);
    nextCycle();

    // fill channel 1 to 8 outstanding, 9th must be held
    for (int i = 1; i < 8; i++) begin
      applyStimulus(1'b1, 2'b00, 1'b1, 3'd0, PW'(i), 7'h0);
      @(negedge clk);
      checkOutput("t2_fill_ready", req_ready, 1'b1);
      nextCycle();
    end
    applyStimulus(1'b1, 2'b10, 1'b1, 3'd0, 15'd8, 7'h0);
    @(negedge clk);
    checkOutput("t2_full_req_ready", req_ready, 1'b0);
    checkOutput("t2_full_cmd_valid", cmd_valid, 1'b0);
    checkOutput("t2_full_head_page", mr_page[1], 15'd0);
    nextCycle();
    returnLine(1'b1, 256'h100);
    nextCycle();
    rd_valid = 1'b0;
    @(negedge clk);
    checkOutput("t2_line0_valid", cd_valid, 2'b10);
    checkOutput("t2_line0_data", line_data[1], 256'h100);
    nextCycle();
    get_next_line = 2'b10;
    @(negedge clk);
    checkOutput("t2_ready_prepop", req_ready, 1'b0);
    nextCycle();
    get_next_line = 2'b00;
    @(negedge clk);
    checkOutput("t2_ready_after_pop", req_ready, 1'b1);
    checkOutput("t2_next_head", mr_page[1], 15'd1);
    checkOutput("t2_cd_after_pop", cd_valid, 2'b00);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 1'b0, 3'd0, 15'h0, 7'h0);

    // drain channel 1 in order
    for (int i = 1; i <= 8; i++) begin
      returnLine(1'b1, DW'(256 + i));
      nextCycle();
      rd_valid      = 1'b0;
      get_next_line = 2'b10;
      @(negedge clk);
      checkOutput("t2_drain_page", mr_page[1], PW'(i));
      checkOutput("t2_drain_line", line_data[1], DW'(256 + i));
      nextCycle();
      get_next_line = 2'b00;
    end
    @(negedge clk);
    checkOutput("t2_drained", mr_valid, 2'b00);

    // interleaved channels, returns in reverse channel order
    nextCycle();
    applyStimulus(1'b1, 2'b01, 1'b0, 3'd0, 15'h100, 7'h0);
    nextCycle();
    applyStimulus(1'b1, 2'b01, 1'b1, 3'd0, 15'h200, 7'h0);
    nextCycle();
    applyStimulus(1'b1, 2'b10, 1'b0, 3'd0, 15'h101, 7'h0);
    nextCycle();
    applyStimulus(1'b1, 2'b10, 1'b1, 3'd0, 15'h201, 7'h0);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 1'b0, 3'd0, 15'h0, 7'h0);
    returnLine(1'b1, 256'hB0);
    nextCycle();
    returnLine(1'b1, 256'hB1);
    nextCycle();
    returnLine(1'b0, 256'hA0);
    nextCycle();
    returnLine(1'b0, 256'hA1);
    nextCycle();
    rd_valid = 1'b0;
    @(negedge clk);
    checkOutput("t4_ch0_page0", mr_page[0], 15'h100);
    checkOutput("t4_ch0_line0", line_data[0], 256'hA0);
    checkOutput("t4_ch1_page0", mr_page[1], 15'h200);
    checkOutput("t4_ch1_line0", line_data[1], 256'hB0);
    get_next_line = 2'b11;
    nextCycle();
    get_next_line = 2'b00;
    @(negedge clk);
    checkOutput("t4_ch0_page1", mr_page[0], 15'h101);
    checkOutput("t4_ch0_line1", line_data[0], 256'hA1);
    checkOutput("t4_ch1_page1", mr_page[1], 15'h201);
    checkOutput("t4_ch1_line1", line_data[1], 256'hB1);
    checkOutput("t4_no_error", error, 1'b0);

    // simultaneous accept and pop on channel 0
    applyStimulus(1'b1, 2'b11, 1'b0, 3'd0, 15'h102, 7'h0);
    get_next_line = 2'b11;
    #1;
    checkOutput("t4_push_pop_ready", req_ready, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 1'b0, 3'd0, 15'h0, 7'h0);
    get_next_line = 2'b00;
    @(negedge clk);
    checkOutput("t4_pp_mr_valid", mr_valid, 2'b01);
    checkOutput("t4_pp_head", mr_page[0], 15'h102);
    checkOutput("t4_pp_cd_valid", cd_valid, 2'b00);
    nextCycle();
    returnLine(1'b0, 256'hA2);
    nextCycle();
    rd_valid = 1'b0;
    @(negedge clk);
    checkOutput("t4_pp_line_valid", cd_valid, 2'b01);
    checkOutput("t4_pp_line", line_data[0], 256'hA2);
    nextCycle();
    get_next_line = 2'b01;
    nextCycle();
    get_next_line = 2'b00;

    // unexpected return on channel 0 with nothing outstanding
    returnLine(1'b0, 256'hEE);
    nextCycle();
    rd_valid = 1'b0;
    @(negedge clk);
    checkOutput("t5_error", error, EXP_ERR);
    checkOutput("t5_cd_valid", cd_valid, 2'b00);
    nextCycle();
    applyStimulus(1'b1, 2'b11, 1'b0, 3'd0, 15'h33, 7'h0);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 1'b0, 3'd0, 15'h0, 7'h0);
    @(negedge clk);
    checkOutput("t5_mr_valid", mr_valid, 2'b01);
    checkOutput("t5_stray_line_stored", cd_valid[0], EXP_STORED);

    // queue more work, then reset mid-stream
    nextCycle();
    applyStimulus(1'b1, 2'b01, 1'b1, 3'd0, 15'h300, 7'h0);
    nextCycle();
    applyStimulus(1'b1, 2'b10, 1'b1, 3'd0, 15'h301, 7'h0);
    nextCycle();
    applyStimulus(1'b1, 2'b11, 1'b0, 3'd0, 15'h34, 7'h0);
    nextCycle();
    returnLine(1'b1, 256'hC0);
    nextCycle();
    rd_valid = 1'b0;
    reset_poweron = 1'b1;
    #1;
    checkOutput("t6_rst_mr_valid", mr_valid, 2'b00);
    checkOutput("t6_rst_cd_valid", cd_valid, 2'b00);
    checkOutput("t6_rst_req_ready", req_ready, 1'b0);
    checkOutput("t6_rst_error", error, 1'b0);
    nextCycle();
    reset_poweron = 1'b0;
    applyStimulus(1'b1, 2'b11, 1'b0, 3'd4, 15'h55, 7'h7);
    @(negedge clk);
    checkOutput("t6_post_ready", req_ready, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 1'b0, 3'd0, 15'h0, 7'h0);
    @(negedge clk);
    checkOutput("t6_post_mr_valid", mr_valid, 2'b01);
    checkOutput("t6_post_head", mr_page[0], 15'h55);
    checkOutput("t6_post_cd_valid", cd_valid, 2'b00);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mmc_sdp_resp_cntl.md
# mmc_sdp_resp_cntl

Main-memory-side responder for the storage-descriptor request/stream protocol. Accepts in-order line read requests from the storage descriptor processor, forwards them to the DRAM command port, and records each request address in a per-channel request-feedback FIFO. Returned DRAM lines go into per-channel data FIFOs. Each line is presented to the descriptor stream controller together with its address, and is popped when the controller pulses get-next-line. Credit control ensures a line FIFO can never overflow.

## Interface
Parameters:
- NUM_CHANNELS, 2, DRAM channels (power of two)
- CHAN_W, 1, channel address width
- BANK_W, 3, bank address width
- PAGE_W, 15, page address width
- WORD_W, 7, word address width
- DATA_W, 256, line width
- FIFO_DEPTH, 8, entries per channel in each FIFO (power of two)

Ports:
- clk  in  1  sole clock
- reset_poweron  in  1  asynchronous, active-high reset
- xxx__mmc__req_valid  in  1  request valid
- xxx__mmc__req_cntl  in  2  01 SOM, 00 MOM, 10 EOM, 11 SOM_EOM
- mmc__xxx__req_ready  out  1  request accepted when valid&ready
- xxx__mmc__req_channel/bank/page/word  in  CHAN_W/BANK_W/PAGE_W/WORD_W  request address
- mmc__dram__cmd_valid  out  1  DRAM read command valid
- mmc__dram__cmd_channel/bank/page/word  out  as request  command address
- dram__mmc__cmd_ready  in  1  DRAM command accepted
- dram__mmc__rd_valid  in  1  returned line valid (no backpressure)
- dram__mmc__rd_channel  in  CHAN_W  channel of returned line
- dram__mmc__rd_data  in  DATA_W  returned line
- mmc__xxx__mem_request_valid  out  NUM_CHANNELS  request FIFO non-empty, per channel
- mmc__xxx__mem_request_cntl  out  2 [NUM_CHANNELS]  head cntl
- mmc__xxx__mem_request_channel/bank/page/word  out  as request [NUM_CHANNELS]  head address
- mmc__xxx__channel_data_valid  out  NUM_CHANNELS  head line available
- mmc__xxx__line_data  out  DATA_W [NUM_CHANNELS]  head line
- xxx__mmc__get_next_line  in  NUM_CHANNELS  pop both FIFOs of channel
- mmc__xxx__error  out  1  sticky protocol error (see Configuration)

## Operation
- Per channel c: request FIFO `rq[c]`, line FIFO `ln[c]`, and outstanding counter `out[c]` (0..FIFO_DEPTH, width log2(FIFO_DEPTH)+1).
- Accept condition for target channel c = req_channel: xxx__mmc__req_valid && !rq_full[c] && out[c] < FIFO_DEPTH && dram__mmc__cmd_ready.
- mmc__dram__cmd_valid = req_valid && !rq_full[c] && out[c]<FIFO_DEPTH. This is combinational and never depends on cmd_ready. Command address equals the request address.
- mmc__xxx__req_ready = the accept condition. Requests with a non-zero channel beyond NUM_CHANNELS-1 cannot occur; only CHAN_W bits are decoded.
- On accept: push {cntl,channel,bank,page,word} into rq[c]; out[c]++.
- On dram__mmc__rd_valid: push rd_data into ln[rd_channel].
- mem_request_valid[c] = !rq_empty[c]. Head fields are driven from the rq[c] read pointer.
- channel_data_valid[c] = !ln_empty[c] && !rq_empty[c].
- get_next_line[c] while channel_data_valid[c]: pop rq[c] and ln[c]; out[c]--.
- get_next_line[c] while not valid: ignored.
- Accept and pop on the same channel in the same cycle: both take effect and out[c] is unchanged. Ready is computed from pre-pop state, so a full FIFO does not accept even when a pop occurs in the same cycle.
- Channels are independent. Order within a channel is strictly FIFO.
- Pointers wrap modulo FIFO_DEPTH. Full/empty is determined by an extra pointer MSB.

## Timing
- Reset (async assert, sync-released internally by flop behaviour) clears all pointers, counters, and error.
- Outputs during reset: all valids 0, req_ready 0, cmd_valid 0, error 0, head fields 0.
- Reset mid-operation flushes all FIFOs. In-flight DRAM returns after reset release are dropped only when the macro is enabled; otherwise they are stored.
- Accept to mem_request_valid: 1 cycle.
- rd_valid to channel_data_valid: 1 cycle (if the request head is present).
- get_next_line pop takes effect on the next edge. The next head is visible the following cycle.
- Sustained throughput: 1 request/cycle/port and 1 pop/cycle/channel.

## Configuration
- MMC_RESP_PROTOCOL_CHECK_EN defined:
  - mmc__xxx__error is set (sticky until reset) on any of:
    - rd_valid for a channel with out[c]==0, or with ln[c] count equal to out[c];
    - get_next_line[c] while !channel_data_valid[c];
    - write to a full ln[c].
  - Erroneous returns are dropped and do not write the FIFO.
- Undefined: no checks, error tied 0, rd_valid always writes.

## Test plan
- Single request ch0 bank 2 page 0x10 word 0x40, cmd_ready=1 → cmd_valid same cycle. Next cycle mem_request_valid[0]=1 with matching head. rd_valid+data 0xA5.. → channel_data_valid[0]=1 next cycle. get_next_line[0] → both valids 0 the cycle after.
- 8 requests to ch1 with no pops → the 9th is held with req_ready=0 and cmd_valid=0. Return 1 line, pop → the 9th is accepted the following cycle.
- cmd_ready=0 for 3 cycles with valid held → cmd_valid=1 and req_ready=0 throughout, no push. Accepted on the first cycle cmd_ready=1.
- Interleaved ch0/ch1 requests, returns in reverse channel order → each channel presents its own lines in its own request order. Simultaneous push and pop leave out[c] unchanged.
- With the macro defined: rd_valid to ch0 with no outstanding requests → error=1, ln[0] stays empty. Same stimulus without the macro → error=0.
- Assert reset_poweron mid-stream with 4 entries queued → all valids 0 immediately. After release, a new request flows with 1-cycle latency.
